// File: rtl/halt_monitor_pkg.sv
// halt_monitor_pkg: shared state and error encodings for halt_monitor.
package halt_monitor_pkg;
  typedef enum logic [1:0] {RUN, SETTLE, DONE} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_TIMEOUT, ERR_HALT_DROP, ERR_WORD_CHG} err_t;
endpackage

// File: rtl/halt_monitor_cmp.sv
// halt_monitor_cmp: NUM_WORDS x WIDTH equality comparator, one mismatch bit.
module halt_monitor_cmp #(
  parameter int WIDTH     = 16,
  parameter int NUM_WORDS = 1
) (
  input  logic [NUM_WORDS*WIDTH-1:0] a,
  input  logic [NUM_WORDS*WIDTH-1:0] b,
  output logic                       mismatch
);
  logic [NUM_WORDS-1:0] ne;
  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
    assign ne[i] = a[i*WIDTH +: WIDTH] != b[i*WIDTH +: WIDTH];
  end
  assign mismatch = |ne;
endmodule

// File: rtl/halt_monitor.sv
// halt_monitor: snapshots words on first halt, reports done SETTLE cycles later.
// Define HALT_MONITOR_CHECK_EN to enable timeout, halt-drop and word-change checks.
module halt_monitor
  import halt_monitor_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_WORDS = 1,
  parameter int TIMEOUT   = 10000,
  parameter int SETTLE    = 5,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt,
  input  logic [NUM_WORDS*WIDTH-1:0] words,
  output logic                       done,
  output logic [1:0]                 err,
  output logic [NUM_WORDS*WIDTH-1:0] snap,
  output logic [CNT_W-1:0]           halt_cyc,
  output logic [CNT_W-1:0]           cyc_cnt
);
  localparam int SW = $clog2(SETTLE + 1);
  state_t         state;
  err_t           err_q;
  logic [SW-1:0]  set_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic           mismatch;
  logic           timeout;
`ifdef HALT_MONITOR_CHECK_EN
  localparam bit CHK = 1'b1;
  halt_monitor_cmp #(.WIDTH(WIDTH), .NUM_WORDS(NUM_WORDS)) u_cmp (
    .a(words), .b(snap), .mismatch(mismatch)
  );
  assign timeout = cnt_nxt > CNT_W'(TIMEOUT);
`else
  localparam bit CHK = 1'b0;
  assign mismatch = 1'b0;
  assign timeout  = 1'b0;
`endif
  assign cnt_nxt = &cyc_cnt ? cyc_cnt : cyc_cnt + 1'b1;
  assign err     = err_q;
  // The timeout edge leaves cyc_cnt at TIMEOUT; every other non-DONE edge advances it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      err_q    <= ERR_NONE;
      done     <= 1'b0;
      snap     <= '0;
      halt_cyc <= '0;
      cyc_cnt  <= '0;
      set_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            snap     <= words;
            halt_cyc <= cnt_nxt;
            cyc_cnt  <= cnt_nxt;
            set_cnt  <= '0;
            state    <= halt_monitor_pkg::SETTLE;
          end else if (CHK && timeout) begin
            err_q <= ERR_TIMEOUT;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cyc_cnt <= cnt_nxt;
          end
        end
        halt_monitor_pkg::SETTLE: begin
          cyc_cnt <= cnt_nxt;
          set_cnt <= set_cnt + 1'b1;
          if (CHK && !halt) begin
            err_q <= ERR_HALT_DROP;
            done  <= 1'b1;
            state <= DONE;
          end else if (CHK && mismatch) begin
            err_q <= ERR_WORD_CHG;
            done  <= 1'b1;
            state <= DONE;
          end else if (set_cnt == SW'(SETTLE - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_halt_monitor.sv
// tb_halt_monitor: scoreboard bench; per-scenario expectations from a cycle-indexed model.
module tb_halt_monitor;
  localparam int W = 16, N = 2, T = 100, S = 5, C = 32, L = T + 30;
`ifdef HALT_MONITOR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, halt = 1'b0;
  logic [N*W-1:0] words = '0;
  logic done;
  logic [1:0] err;
  logic [N*W-1:0] snap;
  logic [C-1:0] halt_cyc, cyc_cnt;

  halt_monitor #(.WIDTH(W), .NUM_WORDS(N), .TIMEOUT(T), .SETTLE(S), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .halt(halt), .words(words), .done(done), .err(err),
    .snap(snap), .halt_cyc(halt_cyc), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dcyc;
    logic [1:0] err;
    logic [N*W-1:0] snap;
    logic [C-1:0] hc;
    logic [C-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int compared = 0, mismatched = 0, cyc = 0;
  bit seen = 1'b0;
  logic hs[1:L];
  logic [N*W-1:0] ws[1:L];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Walk the scheduled inputs: first halt, then the first fault inside the settle window.
  function automatic exp_t model();
    exp_t e;
    int h;
    e = '{dcyc: 0, err: 2'd0, snap: '0, hc: '0, cnt: '0};
    h = 0;
    for (int k = 1; k <= L; k++) if (h == 0 && hs[k]) h = k;
    if (CHK && (h == 0 || h > T + 1)) begin
      e.dcyc = T + 1;
      e.err  = 2'd1;
      e.cnt  = C'(T);
      return e;
    end
    e.hc   = C'(h);
    e.snap = ws[h];
    e.dcyc = h + S;
    if (CHK)
      for (int j = h + 1; j <= h + S; j++) begin
        if (!hs[j]) begin e.err = 2'd2; e.dcyc = j; break; end
        if (ws[j] != ws[h]) begin e.err = 2'd3; e.dcyc = j; break; end
      end
    e.cnt = C'(e.dcyc);
    return e;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done && !seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done at %0d want no done", cyc);
        end else begin
          e = q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.dcyc));
          check("err", 64'(err), 64'(e.err));
          check("snap", 64'(snap), 64'(e.snap));
          check("halt_cyc", 64'(halt_cyc), 64'(e.hc));
          check("cyc_cnt", 64'(cyc_cnt), 64'(e.cnt));
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_snap"}, 64'(snap), 64'd0);
    check({tag, "_halt_cyc"}, 64'(halt_cyc), 64'd0);
    check({tag, "_cyc_cnt"}, 64'(cyc_cnt), 64'd0);
  endtask

  task automatic start();
    rst = 1'b1;
    seen = 1'b0;
    #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run(input int h, input int drop, input int chg, input logic [N*W-1:0] w);
    exp_t e;
    for (int k = 1; k <= L; k++) begin
      hs[k] = h != 0 && k >= h && (drop == 0 || k < drop);
      ws[k] = (chg != 0 && k >= chg) ? w ^ 32'h0100_0000 : w;
    end
    e = model();
    q.push_back(e);
    start();
    for (int k = 1; k <= L && !seen; k++) begin
      halt = hs[k];
      words = ws[k];
      @(posedge clk);
      cyc = k;
      @(negedge clk);
      #1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done in %0d cycles want done at %0d", L, e.dcyc);
      void'(q.pop_front());
    end
    repeat (4) begin
      halt = 1'($urandom);
      words = N*W'($urandom);
      @(negedge clk);
    end
    check("sticky_done", 64'(done), 64'd1);
    check("sticky_err", 64'(err), 64'(e.err));
    check("sticky_cyc_cnt", 64'(cyc_cnt), 64'(e.cnt));
  endtask

  task automatic rst_mid();
    start();
    words = 32'hCAFE_0042;
    for (int k = 1; k <= 22; k++) begin
      halt = k >= 20;
      @(negedge clk);
    end
    rst = 1'b1;
    #1 check_zero("mid_reset");
  endtask

  initial begin
    int h, d, c;
    run(40, 0, 0, 32'hBEEF_1234);
    run(CHK ? 0 : 60, 0, 0, 32'h0BAD_F00D);
    run(20, 23, 23, 32'h5555_AAAA);
    run(20, 0, 23, 32'h5555_AAAA);
    run(T + 1, 0, 0, 32'h1111_2222);
    rst_mid();
    run(10, 0, 0, 32'h3333_4444);
    run(30, 31, 31, 32'h7777_8888);
    repeat (12) begin
      h = $urandom_range(1, T + 8);
      d = ($urandom_range(0, 2) == 0) ? h + $urandom_range(1, S + 1) : 0;
      c = ($urandom_range(0, 2) == 0) ? h + $urandom_range(1, S + 1) : 0;
      run(h, d, c, N*W'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
